// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the video timing generator.
// Holds the default 640x480@60 mode and a 1280x720@60 alternative.
package video_timing_pkg;

    // 640x480@60 (default mode)
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // 1280x720@60
    localparam int unsigned HD_H_ACTIVE = 1280;
    localparam int unsigned HD_H_FP     = 110;
    localparam int unsigned HD_H_SYNC   = 40;
    localparam int unsigned HD_H_BP     = 220;
    localparam int unsigned HD_V_ACTIVE = 720;
    localparam int unsigned HD_V_FP     = 5;
    localparam int unsigned HD_V_SYNC   = 5;
    localparam int unsigned HD_V_BP     = 20;

    localparam bit DEFAULT_SYNC_POL = 1'b1;

    // Bits needed to hold positions 0..count-1 (never less than one bit).
    function automatic int unsigned pos_width(input int unsigned count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

    // Sum of the four intervals that make up one line or one frame.
    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a position counter ordered ACTIVE, FP, SYNC, BP with
// decoded active/sync windows and a wrap strobe for cascading.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned TOTAL     = 800,
    parameter int unsigned ACTIVE    = 640,
    parameter int unsigned FP        = 16,
    parameter int unsigned SYNC      = 96,
    parameter int unsigned POS_WIDTH = pos_width(TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 active,
    output logic                 sync,
    output logic                 wrap
);

    localparam logic [POS_WIDTH-1:0] LAST       = POS_WIDTH'(TOTAL - 1);
    localparam logic [POS_WIDTH-1:0] ACTIVE_END = POS_WIDTH'(ACTIVE);
    localparam logic [POS_WIDTH-1:0] SYNC_START = POS_WIDTH'(ACTIVE + FP);
    localparam logic [POS_WIDTH-1:0] SYNC_END   = POS_WIDTH'(ACTIVE + FP + SYNC);

    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 last;

    assign last = (pos_q == LAST);
    // Wrap only counts when the axis actually steps past its last position.
    assign wrap = advance && last;

    // Next position: clear has priority, otherwise step and wrap.
    always_comb begin
        pos_d = pos_q;
        if (clear) begin
            pos_d = '0;
        end else if (advance) begin
            pos_d = last ? '0 : pos_q + POS_WIDTH'(1);
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    // Window decode from the current position.
    always_comb begin
        pos    = pos_q;
        active = (pos_q < ACTIVE_END);
        sync   = (pos_q >= SYNC_START) && (pos_q < SYNC_END);
    end

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing source: registered de/h_sync/v_sync, active-area coordinates
// and a frame-start pulse, one cycle behind the internal position.
module video_timing_generator
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter bit          SYNC_POL  = DEFAULT_SYNC_POL,
    parameter int unsigned ROW_WIDTH = 10,
    parameter int unsigned COL_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_in,
    output logic                 de_out,
    output logic                 h_sync_out,
    output logic                 v_sync_out,
    output logic [ROW_WIDTH-1:0] row_out,
    output logic [COL_WIDTH-1:0] col_out,
    output logic                 frame_start_out
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_POS_W = pos_width(H_TOTAL);
    localparam int unsigned V_POS_W = pos_width(V_TOTAL);

    // Elaboration-time parameter sanity.
    if (longint'(H_ACTIVE) > (longint'(1) << COL_WIDTH)) begin : g_col_width_check
        $error("H_ACTIVE does not fit in COL_WIDTH");
    end
    if (longint'(V_ACTIVE) > (longint'(1) << ROW_WIDTH)) begin : g_row_width_check
        $error("V_ACTIVE does not fit in ROW_WIDTH");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_h_param_check
        $error("horizontal porch and sync widths must be at least 1");
    end
    if (V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_v_param_check
        $error("vertical porch and sync widths must be at least 1");
    end

    logic               restart;
    logic [H_POS_W-1:0] h_pos;
    logic [V_POS_W-1:0] v_pos;
    logic               h_active, h_sync, h_wrap;
    logic               v_active, v_sync, v_wrap;

    // Disable acts as a synchronous restart at the frame origin.
    assign restart = ~enable_in;

    video_axis_counter #(
        .TOTAL     (H_TOTAL),
        .ACTIVE    (H_ACTIVE),
        .FP        (H_FP),
        .SYNC      (H_SYNC),
        .POS_WIDTH (H_POS_W)
    ) u_h_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (restart),
        .advance (enable_in),
        .pos     (h_pos),
        .active  (h_active),
        .sync    (h_sync),
        .wrap    (h_wrap)
    );

    video_axis_counter #(
        .TOTAL     (V_TOTAL),
        .ACTIVE    (V_ACTIVE),
        .FP        (V_FP),
        .SYNC      (V_SYNC),
        .POS_WIDTH (V_POS_W)
    ) u_v_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (restart),
        .advance (h_wrap),
        .pos     (v_pos),
        .active  (v_active),
        .sync    (v_sync),
        .wrap    (v_wrap)
    );

    // at_origin_q is high exactly when (h_pos, v_pos) == (0, 0); it avoids
    // wide zero compares by tracking the frame wrap instead.
    logic                 at_origin_q, at_origin_d;
    logic                 de_q, de_d;
    logic                 h_sync_q, h_sync_d;
    logic                 v_sync_q, v_sync_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [COL_WIDTH-1:0] col_q, col_d;
    logic                 frame_start_q, frame_start_d;

    // Origin tracking: set on restart or full-frame wrap, else cleared by any step.
    always_comb begin
        at_origin_d = enable_in ? v_wrap : 1'b1;
    end

    // Output next-state: decode current position, or idle levels when disabled.
    always_comb begin
        de_d          = 1'b0;
        h_sync_d      = ~SYNC_POL;
        v_sync_d      = ~SYNC_POL;
        row_d         = '0;
        col_d         = '0;
        frame_start_d = 1'b0;
        if (enable_in) begin
            de_d          = h_active && v_active;
            h_sync_d      = h_sync ? SYNC_POL : ~SYNC_POL;
            v_sync_d      = v_sync ? SYNC_POL : ~SYNC_POL;
            row_d         = de_d ? ROW_WIDTH'(v_pos) : '0;
            col_d         = de_d ? COL_WIDTH'(h_pos) : '0;
            frame_start_d = de_d && at_origin_q;
        end
    end

    // Output and origin-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_origin_q   <= 1'b1;
            de_q          <= 1'b0;
            h_sync_q      <= ~SYNC_POL;
            v_sync_q      <= ~SYNC_POL;
            row_q         <= '0;
            col_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            at_origin_q   <= at_origin_d;
            de_q          <= de_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign de_out          = de_q;
    assign h_sync_out      = h_sync_q;
    assign v_sync_out      = v_sync_q;
    assign row_out         = row_q;
    assign col_out         = col_q;
    assign frame_start_out = frame_start_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator on a tiny 8x6 raster.
module tb_video_timing_generator;

    localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_in;
    logic        de_out, h_sync_out, v_sync_out, frame_start_out;
    logic [9:0]  row_out;
    logic [10:0] col_out;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [9:0]  row;
        logic [10:0] col;
    } obs_t;

    typedef struct {
        int unsigned edge_n;
        obs_t        exp;
    } vec_t;

    localparam obs_t IDLE = '{de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0, row: '0, col: '0};

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned k      = 0;  // cycles since frame origin in the reference model
    vec_t        tbl[$];
    int unsigned fs_edges[$];

    video_timing_generator #(
        .H_ACTIVE  (HA),
        .H_FP      (HF),
        .H_SYNC    (HS),
        .H_BP      (HB),
        .V_ACTIVE  (VA),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB),
        .SYNC_POL  (1'b1),
        .ROW_WIDTH (10),
        .COL_WIDTH (11)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_in       (enable_in),
        .de_out          (de_out),
        .h_sync_out      (h_sync_out),
        .v_sync_out      (v_sync_out),
        .row_out         (row_out),
        .col_out         (col_out),
        .frame_start_out (frame_start_out)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic de, input logic hs, input logic vs, input logic fs,
                                input int unsigned row, input int unsigned col);
        obs_t o;
        o.de  = de;
        o.hs  = hs;
        o.vs  = vs;
        o.fs  = fs;
        o.row = 10'(row);
        o.col = 11'(col);
        return o;
    endfunction

    // Expected outputs for the k-th enabled cycle after the frame origin.
    function automatic obs_t model_at(input int unsigned cyc);
        int unsigned h, v;
        obs_t o;
        h     = cyc % HT;
        v     = (cyc / HT) % VT;
        o.de  = (h < HA) && (v < VA);
        o.hs  = (h >= HA + HF) && (h < HA + HF + HS);
        o.vs  = (v >= VA + VF) && (v < VA + VF + VS);
        o.fs  = o.de && ((cyc % (HT * VT)) == 0);
        o.row = o.de ? 10'(v) : '0;
        o.col = o.de ? 11'(h) : '0;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {de_out, h_sync_out, v_sync_out, frame_start_out, row_out, col_out};
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got de=%0b hs=%0b vs=%0b fs=%0b row=%0d col=%0d, required de=%0b hs=%0b vs=%0b fs=%0b row=%0d col=%0d",
                     name, got.de, got.hs, got.vs, got.fs, got.row, got.col,
                     exp.de, exp.hs, exp.vs, exp.fs, exp.row, exp.col);
        end
    endtask

    task automatic check_int(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // One clock edge with the given enable, compared against the model.
    task automatic tick(input logic en, input string name);
        obs_t exp;
        enable_in = en;
        @(posedge clk);
        #1;
        if (en) begin
            exp = model_at(k);
            k++;
        end else begin
            exp = IDLE;
            k   = 0;
        end
        check(name, sample(), exp);
    endtask

    initial begin
        obs_t got;
        rst_n     = 1'b0;
        enable_in = 1'b0;

        // Hand-derived vectors: edge number after reset release -> outputs.
        tbl.push_back('{1,  mk(1, 0, 0, 1, 0, 0)});
        tbl.push_back('{2,  mk(1, 0, 0, 0, 0, 1)});
        tbl.push_back('{3,  mk(1, 0, 0, 0, 0, 2)});
        tbl.push_back('{4,  mk(1, 0, 0, 0, 0, 3)});
        tbl.push_back('{5,  mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back('{6,  mk(0, 1, 0, 0, 0, 0)});
        tbl.push_back('{7,  mk(0, 1, 0, 0, 0, 0)});
        tbl.push_back('{8,  mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back('{9,  mk(1, 0, 0, 0, 1, 0)});
        tbl.push_back('{25, mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back('{28, mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back('{30, mk(0, 1, 0, 0, 0, 0)});
        tbl.push_back('{31, mk(0, 1, 0, 0, 0, 0)});
        tbl.push_back('{32, mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back('{33, mk(0, 0, 1, 0, 0, 0)});
        tbl.push_back('{36, mk(0, 0, 1, 0, 0, 0)});
        tbl.push_back('{38, mk(0, 1, 1, 0, 0, 0)});
        tbl.push_back('{39, mk(0, 1, 1, 0, 0, 0)});
        tbl.push_back('{40, mk(0, 0, 1, 0, 0, 0)});
        tbl.push_back('{41, mk(0, 0, 0, 0, 0, 0)});
        tbl.push_back('{49, mk(1, 0, 0, 1, 0, 0)});

        #1;
        check("reset_async", sample(), IDLE);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", sample(), IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;

        // Free run over three full frames plus the next origin.
        for (int e = 1; e <= 3 * HT * VT + 1; e++) begin
            tick(1'b1, "run_model");
            got = sample();
            foreach (tbl[i]) begin
                if (tbl[i].edge_n == e) check($sformatf("vec_edge%0d", e), got, tbl[i].exp);
            end
            if (frame_start_out) fs_edges.push_back(e);
        end
        check_int("frame_start_count", fs_edges.size(), 4);
        for (int i = 1; i < fs_edges.size(); i++) begin
            check_int($sformatf("frame_period_%0d", i), fs_edges[i] - fs_edges[i-1], HT * VT);
        end

        // Asynchronous reset mid-line, while an active pixel is presented.
        tick(1'b0, "restart");
        for (int i = 0; i < HT + 2; i++) tick(1'b1, "pre_reset");
        check("pre_reset_pixel", sample(), mk(1, 0, 0, 0, 1, 1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", sample(), IDLE);
        rst_n = 1'b1;
        k     = 0;
        tick(1'b1, "post_reset");
        check("post_reset_origin", sample(), mk(1, 0, 0, 1, 0, 0));

        // Disable for three edges inside the v_sync line, then resume.
        tick(1'b0, "restart2");
        for (int i = 0; i < (VA + VF) * HT + 2; i++) tick(1'b1, "to_vsync");
        check("in_vsync_line", sample(), mk(0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, "disabled");
            check($sformatf("disabled_%0d", i), sample(), mk(0, 0, 0, 0, 0, 0));
        end
        tick(1'b1, "reenable");
        check("reenable_origin", sample(), mk(1, 0, 0, 1, 0, 0));

        // Randomised enable pattern against the model.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 15) != 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
